// File: rtl/sha256_padder.sv
// sha256_padder
// Streaming FIPS 180-4 message padder in front of the SHA-256 core.
// Message words (big-endian, [31:24] = earliest byte) are collected into a
// 512-bit buffer. The padder then appends the 0x80 marker, the zero fill and
// the 64-bit message bit-length, and emits whole blocks over valid/ready.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   data_i         message word, [31:24] is the earliest byte
//   data_valid_i   word valid
//   data_ready_o   padder can accept a word (high only while filling)
//   data_last_i    word is the last of the message
//   data_bytes_i   valid bytes in the last word (0..4, left-aligned, >4 -> 4)
//   block_o        padded block, [511:504] is byte 0
//   block_valid_o  block_o valid
//   block_ready_i  consumer accepts the block
//   block_first_o  block is the first of its message (hash-state reset)
//   block_last_o   block is the final, length-carrying block
module sha256_padder #(
  parameter int BlockWidth = 512,
  parameter int LenWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic                  data_last_i,
  input  logic [2:0]            data_bytes_i,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i,
  output logic                  block_first_o,
  output logic                  block_last_o
);

  localparam int NumBytes = BlockWidth / 8;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic                  state_reg, state_next;
  logic [BlockWidth-1:0] buf_reg, buf_next;
  logic [3:0]            widx_reg, widx_next;
  logic [LenWidth-1:0]   len_reg, len_next;
  logic                  extra_pending_reg, extra_pending_next;
  logic                  marker_pending_reg, marker_pending_next;
  logic                  first_reg, first_next;
  logic                  last_reg, last_next;

  // Byte count of the incoming word: 4 for ordinary words, clamped count for
  // the last word.
  logic [2:0]          nb_eff;
  logic [6:0]          word_base;
  logic [6:0]          marker_pos;
  logic [LenWidth-1:0] len_sum;

  assign nb_eff     = (data_bytes_i > 3'd4) ? 3'd4 : data_bytes_i;
  assign word_base  = {1'b0, widx_reg, 2'b00};
  assign marker_pos = word_base + {4'b0000, nb_eff};
  assign len_sum    = len_reg + (data_last_i ? {{(LenWidth-6){1'b0}}, nb_eff, 3'b000}
                                             : LenWidth'(32));

  // Two candidate buffer images, built byte by byte:
  //   word_img : the incoming word written at widx, everything else kept
  //   last_img : bytes before the current word kept, valid bytes of the last
  //              word written, 0x80 at the marker offset, everything after zero
  logic [BlockWidth-1:0] word_img;
  logic [BlockWidth-1:0] last_img;

  generate
    for (genvar gi = 0; gi < NumBytes; gi++) begin : g_byte
      localparam logic [6:0] ByteIdx = 7'(gi);
      localparam logic [3:0] WordIdx = 4'(gi / 4);
      logic [7:0] old_byte;
      logic [7:0] in_byte;

      assign old_byte = buf_reg[BlockWidth-1-8*gi -: 8];
      assign in_byte  = data_i[31-8*(gi%4) -: 8];

      assign word_img[BlockWidth-1-8*gi -: 8] = (WordIdx == widx_reg) ? in_byte : old_byte;

      // A byte index below marker_pos but not below word_base always lies in
      // the current word, so in_byte is the right lane there.
      assign last_img[BlockWidth-1-8*gi -: 8] =
          (ByteIdx <  word_base)  ? old_byte :
          (ByteIdx <  marker_pos) ? in_byte  :
          (ByteIdx == marker_pos) ? 8'h80    : 8'h00;
    end
  endgenerate

  always_comb begin
    state_next          = state_reg;
    buf_next            = buf_reg;
    widx_next           = widx_reg;
    len_next            = len_reg;
    extra_pending_next  = extra_pending_reg;
    marker_pending_next = marker_pending_reg;
    first_next          = first_reg;
    last_next           = last_reg;

    case (state_reg)
      ST_FILL: begin
        if (data_valid_i) begin
          widx_next = widx_reg + 4'd1;
          len_next  = len_sum;
          if (data_last_i) begin
            buf_next   = last_img;
            state_next = ST_SEND;
            if (marker_pos <= 7'd55) begin
              // Marker and length both fit: this is the final block.
              buf_next[LenWidth-1:0] = len_sum;
              last_next              = 1'b1;
            end else begin
              // No room for the length; a trailing block follows. At offset
              // 64 the marker itself also moves to the trailing block.
              last_next           = 1'b0;
              extra_pending_next  = 1'b1;
              marker_pending_next = (marker_pos == 7'd64);
            end
          end else begin
            buf_next = word_img;
            if (widx_reg == 4'd15) begin
              state_next = ST_SEND;
              last_next  = 1'b0;
            end
          end
        end
      end

      default: begin  // ST_SEND
        if (block_ready_i) begin
          first_next = 1'b0;
          if (extra_pending_reg) begin
            buf_next                          = '0;
            buf_next[BlockWidth-1 -: 8]       = marker_pending_reg ? 8'h80 : 8'h00;
            buf_next[LenWidth-1:0]            = len_reg;
            extra_pending_next                = 1'b0;
            marker_pending_next               = 1'b0;
            last_next                         = 1'b1;
          end else if (last_reg) begin
            // Message complete: start the next one from a clean state.
            len_next   = '0;
            widx_next  = 4'd0;
            buf_next   = '0;
            first_next = 1'b1;
            last_next  = 1'b0;
            state_next = ST_FILL;
          end else begin
            widx_next  = 4'd0;
            last_next  = 1'b0;
            state_next = ST_FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= ST_FILL;
      buf_reg            <= '0;
      widx_reg           <= 4'd0;
      len_reg            <= '0;
      extra_pending_reg  <= 1'b0;
      marker_pending_reg <= 1'b0;
      first_reg          <= 1'b1;
      last_reg           <= 1'b0;
    end else begin
      state_reg          <= state_next;
      buf_reg            <= buf_next;
      widx_reg           <= widx_next;
      len_reg            <= len_next;
      extra_pending_reg  <= extra_pending_next;
      marker_pending_reg <= marker_pending_next;
      first_reg          <= first_next;
      last_reg           <= last_next;
    end
  end

  assign data_ready_o  = (state_reg == ST_FILL);
  assign block_valid_o = (state_reg == ST_SEND);
  assign block_o       = buf_reg;
  assign block_first_o = first_reg;
  assign block_last_o  = last_reg;

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
// Drives byte messages into sha256_padder and compares every emitted block
// against a reference built by plain FIPS 180-4 padding of the message bytes.
module tb_sha256_padder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [31:0]  data_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic         data_last_i;
  logic [2:0]   data_bytes_i;
  logic [511:0] block_o;
  logic         block_valid_o;
  logic         block_ready_i;
  logic         block_first_o;
  logic         block_last_o;

  always #5 clk_i = ~clk_i;

  sha256_padder #(.BlockWidth(512), .LenWidth(64)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .data_ready_o  (data_ready_o),
    .data_last_i   (data_last_i),
    .data_bytes_i  (data_bytes_i),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_blk   = 0;

  byte unsigned msg_q[$];
  logic [511:0] exp_blk[$];
  logic         exp_first[$];
  logic         exp_last[$];
  logic [511:0] blk_hist[$];
  logic         first_hist[$];
  logic         last_hist[$];

  bit hold_ready  = 1'b0;
  bit rand_ready  = 1'b0;
  bit allow_extra = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append the 64-bit
  // big-endian bit length, then cut into 64-byte blocks.
  task automatic build_expected();
    byte unsigned pad[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int           nb;
    pad    = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
    nb = pad.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*b+j];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nb - 1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] bf);
    int guard = 0;
    if (rand_ready) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_i);
        data_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    data_i       = w;
    data_last_i  = last;
    data_bytes_i = bf;
    data_valid_i = 1'b1;
    while (!data_ready_o && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 2000) check("word_accept_timeout", 512'(guard), 512'd0);
    @(posedge clk_i);
  endtask

  task automatic send_msg();
    int           len_b;
    int           nw;
    int           extra;
    int           nb;
    logic [31:0]  w;
    logic         last;
    logic [2:0]   bf;
    len_b = msg_q.size();
    build_expected();
    nw = (len_b + 3) / 4;
    if (nw == 0) nw = 1;
    extra = (allow_extra && len_b > 0 && (len_b % 4) == 0) ? int'($urandom_range(0, 1)) : 0;
    for (int i = 0; i < nw + extra; i++) begin
      w  = $urandom;
      nb = 0;
      for (int k = 0; k < 4; k++) begin
        if (4*i + k < len_b) begin
          w[31-8*k -: 8] = msg_q[4*i+k];
          nb++;
        end
      end
      last = (i == nw + extra - 1);
      if (!last)        bf = 3'($urandom);
      else if (nb == 4) bf = 3'($urandom_range(4, 7));
      else              bf = 3'(nb);
      send_word(w, last, bf);
    end
    @(negedge clk_i);
    data_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while (exp_blk.size() != 0 && g < budget) begin
      @(negedge clk_i);
      g++;
    end
    check("drain", 512'(exp_blk.size()), 512'd0);
    @(negedge clk_i);
  endtask

  task automatic clear_hist();
    blk_hist.delete();
    first_hist.delete();
    last_hist.delete();
  endtask

  // Consumer: chooses block_ready_i at each falling edge; a block seen valid
  // with ready high here is taken on the following rising edge.
  initial begin
    block_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hold_ready)      block_ready_i = 1'b0;
      else if (rand_ready) block_ready_i = ($urandom_range(0, 3) != 0);
      else                 block_ready_i = 1'b1;
      if (rst_ni && block_valid_o && block_ready_i) begin
        blk_hist.push_back(block_o);
        first_hist.push_back(block_first_o);
        last_hist.push_back(block_last_o);
        if (exp_blk.size() == 0) begin
          check("unexpected_block", 512'd1, 512'd0);
        end else begin
          check("block_data",  block_o,       exp_blk.pop_front());
          check("block_first", block_first_o, exp_first.pop_front());
          check("block_last",  block_last_o,  exp_last.pop_front());
        end
        $display("[TB] block %0d first=%0b last=%0b", n_blk, block_first_o, block_last_o);
        n_blk++;
      end
    end
  end

  logic [511:0] snap;

  initial begin
    rst_ni       = 1'b1;
    data_valid_i = 1'b0;
    data_i       = '0;
    data_last_i  = 1'b0;
    data_bytes_i = '0;
    #2 rst_ni = 1'b0;
    #10;
    check("rst_data_ready",  data_ready_o,  1'b1);
    check("rst_block_valid", block_valid_o, 1'b0);
    check("rst_block_first", block_first_o, 1'b1);
    check("rst_block_last",  block_last_o,  1'b0);
    check("rst_block_o",     block_o,       512'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // "abc"
    clear_hist();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    send_msg();
    wait_drain(200);
    check("abc_nblk",  512'(blk_hist.size()), 512'd1);
    check("abc_word0", blk_hist[0][511:480], 512'h61626380);
    check("abc_mid",   blk_hist[0][479:64],  512'd0);
    check("abc_len",   blk_hist[0][63:0],    512'h18);
    check("abc_first", first_hist[0], 1'b1);
    check("abc_last",  last_hist[0],  1'b1);

    // Empty message
    clear_hist();
    msg_q.delete();
    send_msg();
    wait_drain(200);
    check("empty_blk",   blk_hist[0], {8'h80, 504'd0});
    check("empty_first", first_hist[0], 1'b1);
    check("empty_last",  last_hist[0],  1'b1);

    // 56-byte message: marker at byte 56, length in a trailing block
    clear_hist();
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'($urandom));
    send_msg();
    wait_drain(300);
    check("m56_nblk",   512'(blk_hist.size()), 512'd2);
    check("m56_marker", blk_hist[0][63:56], 512'h80);
    check("m56_tail",   blk_hist[0][55:0],  512'd0);
    check("m56_last0",  last_hist[0], 1'b0);
    check("m56_blk1",   blk_hist[1], {448'd0, 64'h1C0});
    check("m56_first1", first_hist[1], 1'b0);
    check("m56_last1",  last_hist[1],  1'b1);

    // 64-byte message: marker moves to the trailing block
    clear_hist();
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
    send_msg();
    wait_drain(300);
    check("m64_nblk",  512'(blk_hist.size()), 512'd2);
    check("m64_last0", last_hist[0], 1'b0);
    check("m64_blk1",  blk_hist[1], {8'h80, 440'd0, 64'h200});
    check("m64_last1", last_hist[1], 1'b1);

    // Backpressure: block held, no word consumed while data_valid_i is high
    hold_ready = 1'b1;
    msg_q.delete();
    for (int i = 0; i < 10; i++) msg_q.push_back(8'($urandom));
    send_msg();
    begin
      int g = 0;
      while (!block_valid_o && g < 50) begin
        @(negedge clk_i);
        g++;
      end
      check("bp_valid", block_valid_o, 1'b1);
    end
    snap = block_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      data_valid_i = 1'b1;
      data_i       = $urandom;
      data_last_i  = 1'b0;
      check("bp_stable", block_o,       snap);
      check("bp_ready",  data_ready_o,  1'b0);
      check("bp_hold",   block_valid_o, 1'b1);
    end
    @(negedge clk_i);
    data_valid_i = 1'b0;
    hold_ready   = 1'b0;
    wait_drain(50);
    check("bp_ready_back", data_ready_o, 1'b1);

    // Reset mid-message, then "abc" again
    for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 3'd4);
    @(negedge clk_i);
    data_valid_i = 1'b0;
    rst_ni       = 1'b0;
    #1;
    check("mrst_block_o", block_o,       512'd0);
    check("mrst_ready",   data_ready_o,  1'b1);
    check("mrst_first",   block_first_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_hist();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    send_msg();
    wait_drain(200);
    check("mrst_abc", blk_hist[0], {32'h61626380, 416'd0, 64'h18});
    check("mrst_abc_first", first_hist[0], 1'b1);

    // Randomized messages with random gaps and random backpressure
    rand_ready  = 1'b1;
    allow_extra = 1'b1;
    for (int m = 0; m < 40; m++) begin
      msg_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 200)); i++) msg_q.push_back(8'($urandom));
      send_msg();
    end
    wait_drain(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
